// File: rtl/uart_frame_rx_pkg.sv
// Shared definitions for the UART command frame path (receive side now, response path later).
// Holds the SOF default, the frame state encoding, frame lengths and the checksum rule.
package uart_frame_rx_pkg;

    localparam logic [7:0] SOF_DEFAULT    = 8'h55;
    localparam int         FRAME_LEN_BASE = 5;
    localparam int         FRAME_LEN_CSUM = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OP     = 3'd1,
        ST_ADDR_H = 3'd2,
        ST_ADDR_L = 3'd3,
        ST_DATA   = 3'd4,
        ST_CSUM   = 3'd5,
        ST_HOLD   = 3'd6
    } state_t;

    function automatic logic [7:0] frame_csum(input logic [7:0] op,
                                              input logic [7:0] addr_h,
                                              input logic [7:0] addr_l,
                                              input logic [7:0] data);
        return op ^ addr_h ^ addr_l ^ data;
    endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte watchdog: counts while enabled, clears on request, saturates at TIMEOUT_CYC-1.
// expire is high while enabled and the count sits at its last value.
module uart_byte_timer #(
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int         W    = $clog2(TIMEOUT_CYC);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/uart_frame_rx.sv
// Frames the uart_rx byte stream into [SOF, OP, ADDR_H, ADDR_L, DATA] commands.
// Define UART_FRAME_CSUM_EN to require a trailing XOR checksum byte after DATA.
module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 20000,
    parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        po_flag,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_op,
    output logic [15:0] cmd_addr,
    output logic [7:0]  cmd_data,
    output logic        to_err,
    output logic        ovf_err,
    output logic        csum_err,
    output logic [2:0]  dbg_state
);

    // Handshake: cmd_valid rises the cycle after the completing byte and stays high with
    // cmd_op/addr/data frozen until a clock edge sees cmd_valid && cmd_ready.
    state_t state, state_next;

    logic [7:0] op_q, addr_h_q, addr_l_q;
    logic       frame_done, to_set, ovf_set;
    logic       in_frame, timer_expire;
`ifdef UART_FRAME_CSUM_EN
    logic [7:0] data_q;
    logic       csum_set;
    logic       csum_q;
`endif

    assign in_frame = (state == ST_OP) || (state == ST_ADDR_H) || (state == ST_ADDR_L)
                   || (state == ST_DATA) || (state == ST_CSUM);

    uart_byte_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (po_flag || !in_frame),
        .enable (in_frame),
        .expire (timer_expire)
    );

    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        to_set     = 1'b0;
        ovf_set    = 1'b0;
`ifdef UART_FRAME_CSUM_EN
        csum_set   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (po_flag && rx_data == SOF_BYTE) state_next = ST_OP;
            end
            ST_OP: begin
                if (po_flag) state_next = ST_ADDR_H;
            end
            ST_ADDR_H: begin
                if (po_flag) state_next = ST_ADDR_L;
            end
            ST_ADDR_L: begin
                if (po_flag) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (po_flag) begin
`ifdef UART_FRAME_CSUM_EN
                    state_next = ST_CSUM;
`else
                    state_next = ST_HOLD;
                    frame_done = 1'b1;
`endif
                end
            end
`ifdef UART_FRAME_CSUM_EN
            ST_CSUM: begin
                if (po_flag) begin
                    if (rx_data == frame_csum(op_q, addr_h_q, addr_l_q, data_q)) begin
                        state_next = ST_HOLD;
                        frame_done = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        csum_set   = 1'b1;
                    end
                end
            end
`endif
            ST_HOLD: begin
                // Retiring frees the slot this cycle, so a concurrent byte is hunted as in IDLE.
                if (cmd_ready) begin
                    state_next = (po_flag && rx_data == SOF_BYTE) ? ST_OP : ST_IDLE;
                end else if (po_flag) begin
                    ovf_set = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (in_frame && !po_flag && timer_expire) begin
            state_next = ST_IDLE;
            to_set     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            addr_h_q <= '0;
            addr_l_q <= '0;
            cmd_op   <= '0;
            cmd_addr <= '0;
            cmd_data <= '0;
            to_err   <= 1'b0;
            ovf_err  <= 1'b0;
`ifdef UART_FRAME_CSUM_EN
            data_q   <= '0;
            csum_q   <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            to_err  <= to_set;
            ovf_err <= ovf_set;
`ifdef UART_FRAME_CSUM_EN
            csum_q  <= csum_set;
`endif
            if (po_flag) begin
                case (state)
                    ST_OP:     op_q     <= rx_data;
                    ST_ADDR_H: addr_h_q <= rx_data;
                    ST_ADDR_L: addr_l_q <= rx_data;
`ifdef UART_FRAME_CSUM_EN
                    ST_DATA:   data_q   <= rx_data;
`endif
                    default: ;
                endcase
            end
            // Outputs only change when a whole frame has been accepted.
            if (frame_done) begin
                cmd_op   <= op_q;
                cmd_addr <= {addr_h_q, addr_l_q};
`ifdef UART_FRAME_CSUM_EN
                cmd_data <= data_q;
`else
                cmd_data <= rx_data;
`endif
            end
        end
    end

    assign cmd_valid = (state == ST_HOLD);
    assign dbg_state = state;
`ifdef UART_FRAME_CSUM_EN
    assign csum_err  = csum_q;
`else
    assign csum_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed plus randomized bench for uart_frame_rx with a queue-based frame model.
// Honours UART_FRAME_CSUM_EN the same way as the design.
module tb_uart_frame_rx;
  import uart_frame_rx_pkg::*;

  localparam int T = 16;
`ifdef UART_FRAME_CSUM_EN
  localparam int FLEN = FRAME_LEN_CSUM;
`else
  localparam int FLEN = FRAME_LEN_BASE;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        po_flag;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        to_err;
  logic        ovf_err;
  logic        csum_err;
  logic [2:0]  dbg_state;

  uart_frame_rx #(.TIMEOUT_CYC(T), .SOF_BYTE(8'h55)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .po_flag   (po_flag),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .to_err    (to_err),
    .ovf_err   (ovf_err),
    .csum_err  (csum_err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  frm[$];
  int last_cyc = 0;
  int exp_to = 0, exp_ovf = 0, exp_csum = 0;
  int seen_to = 0, seen_ovf = 0, seen_csum = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (to_err) seen_to++;
      if (ovf_err) seen_ovf++;
      if (csum_err) seen_csum++;
      if (cmd_valid && cmd_ready) begin
        check("cmd_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("cmd_fields", {cmd_op, cmd_addr, cmd_data}, exp_q.pop_front());
      end
    end
  end

  // Frame model: a byte gap of more than T cycles inside a frame drops the partial frame.
  task automatic model_byte(input logic [7:0] b);
    int gap;
    gap = cyc - last_cyc;
    last_cyc = cyc;
    if (frm.size() > 0 && gap > T) begin
      frm.delete();
      exp_to++;
    end
    if (frm.size() == 0) begin
      if (b == 8'h55) frm.push_back(b);
    end else begin
      frm.push_back(b);
      if (frm.size() == FLEN) begin
        if (FLEN == FRAME_LEN_CSUM && b != (frm[1] ^ frm[2] ^ frm[3] ^ frm[4])) exp_csum++;
        else exp_q.push_back({frm[1], frm[2], frm[3], frm[4]});
        frm.delete();
      end
    end
  endtask

  task automatic model_flush();
    if (frm.size() > 0 && (cyc - last_cyc) > T) begin
      frm.delete();
      exp_to++;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_byte(input logic [7:0] b, input int idle);
    repeat (idle) @(posedge clk);
    #1;
    rx_data = b;
    po_flag = 1'b1;
    @(posedge clk);
    #1;
    po_flag = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input int idle);
    drive_byte(b, idle);
    model_byte(b);
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [15:0] addr,
                            input logic [7:0] data, input logic bad_csum, input int idle);
    send_byte(8'h55, idle);
    send_byte(op, idle);
    send_byte(addr[15:8], idle);
    send_byte(addr[7:0], idle);
    send_byte(data, idle);
`ifdef UART_FRAME_CSUM_EN
    send_byte(op ^ addr[15:8] ^ addr[7:0] ^ data ^ (bad_csum ? 8'h01 : 8'h00), idle);
`else
    if (bad_csum) rx_data = 8'h00;
`endif
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int to_before;
    rst = 1'b1;
    po_flag = 1'b0;
    rx_data = 8'h00;
    cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    last_cyc = cyc;
    @(negedge clk);
    check("rst_valid", cmd_valid, 0);
    check("rst_op", cmd_op, 0);
    check("rst_addr", cmd_addr, 0);
    check("rst_data", cmd_data, 0);
    check("rst_errs", {to_err, ovf_err, csum_err}, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // basic frame, one-cycle latency, retire with ready high
    send_frame(8'h02, 16'h1234, 8'hA5, 1'b0, 0);
    check("t1_latency", cmd_valid, 1);
    check("t1_op", cmd_op, 8'h02);
    check("t1_addr", cmd_addr, 16'h1234);
    check("t1_data", cmd_data, 8'hA5);
    @(posedge clk);
    #1;
    check("t1_retire", cmd_valid, 0);
    check("t1_errs", {to_err, ovf_err, csum_err}, 0);

    // leading junk ignored
    send_byte(8'h00, 2);
    send_byte(8'hFF, 0);
    send_frame(8'h01, 16'h0010, 8'h7E, 1'b0, 1);
    check("t2_valid", cmd_valid, 1);
    check("t2_fields", {cmd_op, cmd_addr, cmd_data}, 32'h0100107E);
    repeat (2) @(posedge clk);

    // inter-byte timeout
    to_before = seen_to;
    send_byte(8'h55, 3);
    send_byte(8'h03, 0);
    repeat (T + 4) @(posedge clk);
    #1;
    model_flush();
    check("t3_to_once", seen_to - to_before, 1);
    check("t3_to_model", seen_to, exp_to);
    check("t3_no_cmd", cmd_valid, 0);
    check("t3_state", dbg_state, ST_IDLE);
    send_frame(8'h04, 16'h5678, 8'h9A, 1'b0, 2);
    check("t3_recover", {cmd_valid, cmd_op, cmd_addr, cmd_data}, 32'h0456789A | 32'h0);
    check("t3_recover_valid", cmd_valid, 1);
    repeat (2) @(posedge clk);

    // overrun while holding
    cmd_ready = 1'b0;
    send_frame(8'h11, 16'hBEEF, 8'h5A, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_hold_valid", cmd_valid, 1);
    check("t4_hold_state", dbg_state, ST_HOLD);
    drive_byte(8'h55, 0);
    exp_ovf++;
    check("t4_ovf_pulse", ovf_err, 1);
    check("t4_fields_kept", {cmd_op, cmd_addr, cmd_data}, 32'h11BEEF5A);
    cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4_drop", cmd_valid, 0);
    check("t4_ovf_once", seen_ovf, exp_ovf);

    // bad checksum (plain frame when checksum is disabled)
    send_frame(8'h02, 16'h1234, 8'hA5, 1'b1, 0);
`ifdef UART_FRAME_CSUM_EN
    check("t5_csum_pulse", csum_err, 1);
    check("t5_no_cmd", cmd_valid, 0);
`else
    check("t5_csum_tied", csum_err, 0);
    check("t5_cmd", cmd_valid, 1);
`endif
    repeat (2) @(posedge clk);

    // reset mid-frame
    send_byte(8'h55, 1);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    frm.delete();
    last_cyc = cyc;
    check("t6_rst_outs", {cmd_valid, to_err, ovf_err, csum_err, dbg_state}, 0);
    check("t6_rst_fields", {cmd_op, cmd_addr, cmd_data}, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'hA5, 0);
    @(posedge clk);
    #1;
    check("t6_not_decoded", cmd_valid, 0);
    check("t6_state", dbg_state, ST_IDLE);

    // randomized traffic against the model
    for (int f = 0; f < 40; f++) begin
      int idle;
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), $urandom_range(0, 4));
      idle = ($urandom_range(0, 7) == 0) ? T + $urandom_range(0, 2) - 1 : $urandom_range(0, 3);
      send_frame(8'($urandom), 16'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), idle);
    end
    repeat (T + 4) @(posedge clk);
    #1;
    model_flush();
    @(negedge clk);

    check("end_to_count", seen_to, exp_to);
    check("end_ovf_count", seen_ovf, exp_ovf);
    check("end_csum_count", seen_csum, exp_csum);
    check("end_cmd_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
